// File: rtl/tb_pkg.sv
// tb_pkg: shared address codes, commit FSM states and default divide values for time_base_ctrl
package tb_pkg;
  typedef enum logic [1:0] {A_TIC = 2'd0, A_ACCUM = 2'd1, A_COMMIT = 2'd2, A_IRQ = 2'd3} addr_e;
  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_e;
  localparam logic [23:0] DEF_TIC = 24'h18FFFF;
  localparam logic [23:0] DEF_ACCUM = 24'h001FFF;
endpackage

// File: rtl/time_base_ctrl_if.sv
// time_base_ctrl_if: host write bus (wr_en/wr_addr/wr_data from host, wr_ack back to host)
interface time_base_ctrl_if;
  logic wr_en;
  logic [1:0] wr_addr;
  logic [23:0] wr_data;
  logic wr_ack;
  modport master(output wr_en, wr_addr, wr_data, input wr_ack);
  modport slave(input wr_en, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/accum_irq_ctrl.sv
// accum_irq_ctrl: latched accumulation interrupt and saturating overrun counter
// ports: clk, rstn (sync, active-low), accum_enable, clr_irq, clr_ovr in; accum_irq, overrun_count out
module accum_irq_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic       accum_enable,
  input  logic       clr_irq,
  input  logic       clr_ovr,
  output logic       accum_irq,
  output logic [7:0] overrun_count
);
  // a same-cycle clear counts as servicing the old interrupt, so it suppresses the overrun
  always_ff @(posedge clk)
    if (!rstn) begin
      accum_irq <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      accum_irq <= accum_enable | (accum_irq & ~clr_irq);
      overrun_count <= clr_ovr ? 8'd0 :
                       (accum_enable & accum_irq & ~clr_irq & ~&overrun_count) ? overrun_count + 8'd1 :
                       overrun_count;
    end
endmodule

// File: rtl/time_base_ctrl.sv
// time_base_ctrl: shadow/staged divide registers with TIC-aligned commit, IRQ block and TIC sequence counter
// ports: clk, rstn (sync, active-low), bus (host write bus, slave), pre_tic_enable, accum_enable in;
//        tic_divide, accum_divide, commit_busy, applied, accum_irq, overrun_count, tic_seq out
module time_base_ctrl
  import tb_pkg::*;
#(
  parameter logic [23:0] DEFAULT_TIC = DEF_TIC,
  parameter logic [23:0] DEFAULT_ACCUM = DEF_ACCUM
) (
  input  logic                clk,
  input  logic                rstn,
  time_base_ctrl_if.slave     bus,
  input  logic                pre_tic_enable,
  input  logic                accum_enable,
  output logic [23:0]         tic_divide,
  output logic [23:0]         accum_divide,
  output logic                commit_busy,
  output logic                applied,
  output logic                accum_irq,
  output logic [7:0]          overrun_count,
  output logic [15:0]         tic_seq
);
  state_e state, state_nx;
  logic [23:0] sh_tic, sh_acc, st_tic, st_acc;
  logic commit, imm, dfr, tic_apply;
  // any commit in the TIC cycle wins over the TIC, so the TIC only applies when no commit is present
  always_comb begin
    commit = bus.wr_en && bus.wr_addr == A_COMMIT;
    imm = commit && bus.wr_data[0];
    dfr = commit && !bus.wr_data[0];
    tic_apply = state == ARMED && pre_tic_enable && !commit;
    state_nx = dfr ? ARMED : (imm || tic_apply) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (!rstn) begin
      sh_tic <= DEFAULT_TIC;
      sh_acc <= DEFAULT_ACCUM;
      st_tic <= DEFAULT_TIC;
      st_acc <= DEFAULT_ACCUM;
      tic_divide <= DEFAULT_TIC;
      accum_divide <= DEFAULT_ACCUM;
      bus.wr_ack <= 1'b0;
      applied <= 1'b0;
      tic_seq <= 16'd0;
    end else begin
      bus.wr_ack <= bus.wr_en;
      applied <= imm | tic_apply;
      tic_seq <= tic_seq + {15'd0, pre_tic_enable};
      if (bus.wr_en && bus.wr_addr == A_TIC) sh_tic <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == A_ACCUM) sh_acc <= bus.wr_data;
      if (dfr) begin
        st_tic <= sh_tic;
        st_acc <= sh_acc;
      end
      if (imm) begin
        tic_divide <= sh_tic;
        accum_divide <= sh_acc;
      end else if (tic_apply) begin
        tic_divide <= st_tic;
        accum_divide <= st_acc;
      end
    end
  assign commit_busy = state == ARMED;
  accum_irq_ctrl u_irq (
    .clk(clk),
    .rstn(rstn),
    .accum_enable(accum_enable),
    .clr_irq(bus.wr_en && bus.wr_addr == A_IRQ && bus.wr_data[0]),
    .clr_ovr(bus.wr_en && bus.wr_addr == A_IRQ && bus.wr_data[1]),
    .accum_irq(accum_irq),
    .overrun_count(overrun_count)
  );
endmodule

// File: tb/tb_time_base_ctrl.sv
// tb_time_base_ctrl: scoreboard bench with directed and random stimulus against a behavioural model
module tb_time_base_ctrl;
  typedef struct {
    logic [23:0] tic, acc;
    logic busy, app, irq, ack;
    logic [7:0] ovr;
    logic [15:0] seq;
  } exp_t;
  typedef struct {
    logic [23:0] tic, acc;
  } pair_t;
  logic clk, rstn, pre_tic_enable, accum_enable;
  logic [23:0] tic_divide, accum_divide;
  logic commit_busy, applied, accum_irq;
  logic [7:0] overrun_count;
  logic [15:0] tic_seq;
  int checks = 0, errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  pair_t pend[$];
  pair_t shadow, active;
  logic m_irq, m_app, m_ack;
  int m_ovr, m_seq;
  time_base_ctrl_if bus ();
  time_base_ctrl dut (
    .clk(clk), .rstn(rstn), .bus(bus), .pre_tic_enable(pre_tic_enable), .accum_enable(accum_enable),
    .tic_divide(tic_divide), .accum_divide(accum_divide), .commit_busy(commit_busy), .applied(applied),
    .accum_irq(accum_irq), .overrun_count(overrun_count), .tic_seq(tic_seq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock of stimulus; the model advances by the documented rules and its result is queued
  task automatic step(input logic en, input logic [1:0] a, input logic [23:0] d, input logic pt, input logic ae, input logic rn);
    pair_t p;
    exp_t e;
    bit clr_i, clr_o, over;
    @(negedge clk);
    bus.wr_en = en; bus.wr_addr = a; bus.wr_data = d;
    pre_tic_enable = pt; accum_enable = ae; rstn = rn;
    if (!rn) begin
      shadow = '{24'h18FFFF, 24'h001FFF};
      active = shadow;
      pend.delete();
      m_irq = 0; m_ovr = 0; m_seq = 0; m_app = 0; m_ack = 0;
    end else begin
      m_ack = en;
      m_app = 0;
      if (en && a == 2 && d[0]) begin
        active = shadow;
        pend.delete();
        m_app = 1;
      end else if (en && a == 2) begin
        pend.delete();
        pend.push_back(shadow);
      end else if (pt && pend.size() != 0) begin
        p = pend.pop_front();
        active = p;
        m_app = 1;
      end
      if (en && a == 0) shadow.tic = d;
      if (en && a == 1) shadow.acc = d;
      m_seq = (m_seq + int'(pt)) % 65536;
      clr_i = en && a == 3 && d[0];
      clr_o = en && a == 3 && d[1];
      over = ae && m_irq && !clr_i;
      m_ovr = clr_o ? 0 : (m_ovr + int'(over) > 255 ? 255 : m_ovr + int'(over));
      m_irq = ae ? 1'b1 : clr_i ? 1'b0 : m_irq;
    end
    e.tic = active.tic; e.acc = active.acc; e.busy = pend.size() != 0; e.app = m_app;
    e.irq = m_irq; e.ack = m_ack; e.ovr = 8'(m_ovr); e.seq = 16'(m_seq);
    sb.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("tic_divide", 32'(tic_divide), 32'(mon_e.tic));
        chk("accum_divide", 32'(accum_divide), 32'(mon_e.acc));
        chk("commit_busy", 32'(commit_busy), 32'(mon_e.busy));
        chk("applied", 32'(applied), 32'(mon_e.app));
        chk("accum_irq", 32'(accum_irq), 32'(mon_e.irq));
        chk("wr_ack", 32'(bus.wr_ack), 32'(mon_e.ack));
        chk("overrun_count", 32'(overrun_count), 32'(mon_e.ovr));
        chk("tic_seq", 32'(tic_seq), 32'(mon_e.seq));
      end
    end
  end
  initial begin
    rstn = 1'b0; pre_tic_enable = 1'b0; accum_enable = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 24'd0;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 24'h0003FF, 0, 0, 1);
    step(1, 1, 24'h00007F, 0, 0, 1);
    step(1, 2, 24'h0, 0, 0, 1);
    idle(10);
    step(0, 0, 0, 1, 0, 1);
    idle(3);
    step(1, 0, 24'h123456, 0, 0, 1);
    step(1, 2, 24'h0, 1, 0, 1);
    idle(3);
    step(0, 0, 0, 1, 0, 1);
    idle(2);
    step(1, 1, 24'h00ABCD, 0, 0, 1);
    step(1, 2, 24'h0, 0, 0, 1);
    step(1, 0, 24'h000111, 0, 0, 1);
    step(1, 2, 24'h1, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle(2);
    step(1, 3, 24'h3, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 1);
      idle(1);
    end
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, 1);
    step(1, 3, 24'h1, 0, 1, 1);
    step(1, 3, 24'h2, 0, 1, 1);
    step(1, 3, 24'h3, 0, 0, 1);
    for (int i = 0; i < 65536; i++) step(0, 0, 0, 1, 0, 1);
    step(1, 0, 24'h000222, 0, 0, 1);
    step(1, 2, 24'h0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 24'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 99) != 0));
    idle(3);
    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_base_ctrl.md
TIME_BASE_CTRL -- requirements
Module: time_base_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_TIC, default 24'h18FFFF, reset value of tic_divide (0.1 s at 16.384 MHz).
REQ-002 SHALL have parameter DEFAULT_ACCUM, default 24'h001FFF, reset value of accum_divide (0.5 ms).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 wr_en  input  1  host write strobe, one cycle per write.
REQ-006 wr_addr  input  2  0 = tic shadow, 1 = accum shadow, 2 = commit, 3 = irq control.
REQ-007 wr_data  input  24  write data.
REQ-008 wr_ack  output  1  one-cycle pulse, the cycle after each accepted wr_en.
REQ-009 pre_tic_enable  input  1  TIC boundary pulse from the time base.
REQ-010 accum_enable  input  1  accumulation-interval pulse from the time base.
REQ-011 tic_divide  output  24  active TIC divide value to the time base.
REQ-012 accum_divide  output  24  active accum divide value to the time base.
REQ-013 commit_busy  output  1  high while a commit is armed for the next TIC.
REQ-014 applied  output  1  one-cycle pulse when staged values become active.
REQ-015 accum_irq  output  1  latched accumulation interrupt.
REQ-016 overrun_count  output  8  missed-interrupt count, saturating.
REQ-017 tic_seq  output  16  TIC sequence number.

Function
REQ-018 Writes to addr 0/1 SHALL load the tic/accum shadow registers at the next edge; the active outputs are not affected.
REQ-019 A write to addr 2 with wr_data[0]=1 (immediate) SHALL copy both shadows to tic_divide/accum_divide at the next edge, pulse applied, and cancel any armed commit.
REQ-020 A write to addr 2 with wr_data[0]=0 SHALL copy both shadows to staged registers and enter state ARMED (commit_busy=1).
REQ-021 FSM states: IDLE, ARMED; IDLE->ARMED on deferred commit; ARMED->IDLE on pre_tic_enable (staged->active, applied pulse, same edge) or on immediate commit.
REQ-022 A deferred commit while ARMED SHALL overwrite staged values and stay ARMED.
REQ-023 A commit in the same cycle as pre_tic_enable SHALL take priority: the TIC does not apply, the state is ARMED with the new staged values.
REQ-024 A write to addr 3 SHALL clear accum_irq if wr_data[0]=1 and clear overrun_count if wr_data[1]=1.
REQ-025 accum_enable SHALL set accum_irq at the next edge.
REQ-026 accum_enable with accum_irq already 1 and no same-cycle clear SHALL increment overrun_count, saturating at 255.
REQ-027 accum_enable and an irq clear in the same cycle SHALL leave accum_irq=1 with no overrun; an overrun-count clear plus overrun in the same cycle SHALL give overrun_count=0.
REQ-028 tic_seq SHALL increment on each pre_tic_enable and wrap 16'hFFFF->0.
REQ-029 wr_ack SHALL pulse for every wr_en, including writes to any address while ARMED.

Reset
REQ-030 rstn=0 SHALL set tic_divide=DEFAULT_TIC, accum_divide=DEFAULT_ACCUM, shadows and staged to the same defaults, state IDLE, and all other outputs to 0.
REQ-031 Reset while ARMED SHALL discard the staged values; no applied pulse.

Structure
REQ-032 Address codes, FSM state encoding and default divides SHALL live in a shared package, tb_pkg.
REQ-033 The interrupt/overrun logic SHALL be the single sub-module accum_irq_ctrl; the FSM and registers stay in the top level.

Verification
REQ-034 After reset -> tic_divide=24'h18FFFF, accum_divide=24'h001FFF, accum_irq=0, tic_seq=0.
REQ-035 Write addr0=24'h0003FF, addr1=24'h00007F, addr2=0, then pre_tic_enable 10 cycles later -> commit_busy=1 until the TIC; outputs update on the TIC edge, applied pulses once.
REQ-036 Deferred commit in the same cycle as pre_tic_enable -> outputs unchanged, commit_busy=1; the next pre_tic_enable applies.
REQ-037 Three accum_enable pulses with no clear -> accum_irq=1, overrun_count=2; 300 pulses -> overrun_count=255.
REQ-038 accum_enable plus addr3 data=1 in the same cycle -> accum_irq=1, overrun_count unchanged.
REQ-039 65536 pre_tic_enable pulses -> tic_seq=0; rstn low while ARMED -> defaults restored, commit_busy=0.
